// File: rtl/arbiter_wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Mode encodings are shared with the older arbiter block.
package arbiter_wrr_pkg;

    typedef enum logic {
        ARB_MODE_RR   = 1'b0,
        ARB_MODE_PRIO = 1'b1
    } arb_mode_e;

    localparam int DEFAULT_NUM_PORTS = 9;
    localparam int DEFAULT_WEIGHT_W  = 4;

endpackage

// File: rtl/arbiter_wrr_if.sv
// Requester/arbiter signal bundle.
// The master side drives requests and weights; the slave side returns the grant.
interface arbiter_wrr_if #(
    parameter int NUM_PORTS = 9,
    parameter int WEIGHT_W  = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
);
    logic                          mode;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight;
    logic [NUM_PORTS-1:0]          request;
    logic [NUM_PORTS-1:0]          grant;
    logic [SEL_W-1:0]              select;
    logic                          active;
    logic                          handover;

    modport master (
        output mode, weight, request,
        input  grant, select, active, handover
    );

    modport slave (
        input  mode, weight, request,
        output grant, select, active, handover
    );
endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational picker: round-robin after ptr, or lowest index in priority mode.
// Uses a double-width masked priority encoder so the wrap needs no rotator.
module arbiter_rr_pick
    import arbiter_wrr_pkg::*;
#(
    parameter  int NUM_PORTS = 9,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [SEL_W-1:0]     ptr,
    input  logic                 mode,
    output logic [NUM_PORTS-1:0] pick,
    output logic [SEL_W-1:0]     index,
    output logic                 any
);
    logic [NUM_PORTS-1:0]   upper_mask;
    logic [2*NUM_PORTS-1:0] dbl_req;
    logic [SEL_W:0]         pos_dbl;

    // Lower copy keeps only ports after ptr; the upper copy supplies the wrap,
    // so the port at ptr itself ranks last. Priority mode empties the lower copy.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
            assign upper_mask[gi] = (mode == ARB_MODE_RR) && (gi > int'(ptr));
            assign pick[gi]       = any && (index == SEL_W'(gi));
        end
    endgenerate

    assign dbl_req = {request, request & upper_mask};
    assign any     = |request;

    always_comb begin
        pos_dbl = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
            if (dbl_req[i]) pos_dbl = (SEL_W+1)'(i);
        end
        if (pos_dbl >= (SEL_W+1)'(NUM_PORTS))
            index = SEL_W'(pos_dbl - (SEL_W+1)'(NUM_PORTS));
        else
            index = pos_dbl[SEL_W-1:0];
    end
endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: registered one-hot grant held for a per-port
// number of cycles, with gapless handover and optional fixed priority.
module arbiter_wrr
    import arbiter_wrr_pkg::*;
#(
    parameter  int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter  int WEIGHT_W  = DEFAULT_WEIGHT_W,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input logic         clk,
    input logic         rst,
    arbiter_wrr_if.slave bus
);
    logic [WEIGHT_W-1:0]  weight_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] pick;
    logic [SEL_W-1:0]     pick_index;
    logic                 pick_any;

    logic [NUM_PORTS-1:0] grant_reg,     grant_next;
    logic [SEL_W-1:0]     select_reg,    select_next;
    logic [SEL_W-1:0]     ptr_reg,       ptr_next;
    logic [WEIGHT_W-1:0]  credit_reg,    credit_next;
    logic                 unlimited_reg, unlimited_next;
    logic                 active_reg;
    logic                 handover_reg;
    logic                 owner_req;
    logic                 keep;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_weight
            assign weight_arr[gi] = bus.weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .request (bus.request),
        .ptr     (ptr_reg),
        .mode    (bus.mode),
        .pick    (pick),
        .index   (pick_index),
        .any     (pick_any)
    );

    // Unlimited-ness is latched at grant time so a mid-grant weight edit
    // cannot stretch or cut the running grant.
    assign owner_req = |(grant_reg & bus.request);
    assign keep      = owner_req && (unlimited_reg || (credit_reg > WEIGHT_W'(1)));

    always_comb begin
        grant_next     = grant_reg;
        select_next    = select_reg;
        ptr_next       = ptr_reg;
        credit_next    = credit_reg;
        unlimited_next = unlimited_reg;
        if (keep) begin
            if (!unlimited_reg) credit_next = credit_reg - WEIGHT_W'(1);
        end else if (pick_any) begin
            grant_next     = pick;
            select_next    = pick_index;
            ptr_next       = pick_index;
            credit_next    = weight_arr[pick_index];
            unlimited_next = (weight_arr[pick_index] == '0);
        end else begin
            grant_next     = '0;
            credit_next    = '0;
            unlimited_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg     <= '0;
            select_reg    <= '0;
            ptr_reg       <= SEL_W'(NUM_PORTS-1);
            credit_reg    <= '0;
            unlimited_reg <= 1'b0;
            active_reg    <= 1'b0;
            handover_reg  <= 1'b0;
        end else begin
            grant_reg     <= grant_next;
            select_reg    <= select_next;
            ptr_reg       <= ptr_next;
            credit_reg    <= credit_next;
            unlimited_reg <= unlimited_next;
            active_reg    <= |grant_next;
            handover_reg  <= (grant_next != grant_reg) && (|grant_next);
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.select   = select_reg;
    assign bus.active   = active_reg;
    assign bus.handover = handover_reg;
endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr with hand-computed grant sequences.
module tb_arbiter_wrr;
    localparam int NP = 9;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    arbiter_wrr_if #(.NUM_PORTS(NP), .WEIGHT_W(WW)) bus ();

    arbiter_wrr #(.NUM_PORTS(NP), .WEIGHT_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // port < 0 means idle; select is checked only when a port is expected.
    task automatic expect_state(input string tag, input int port, input logic ho);
        logic [NP-1:0] exp_grant;
        exp_grant = (port < 0) ? '0 : (NP'(1) << port);
        $display("%0t %s req=%h grant=%h select=%0d active=%0b handover=%0b",
                 $time, tag, bus.request, bus.grant, bus.select, bus.active, bus.handover);
        check_eq({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        check_eq({tag, ".active"}, 32'(bus.active), 32'(port >= 0));
        check_eq({tag, ".handover"}, 32'(bus.handover), 32'(ho));
        if (port >= 0) check_eq({tag, ".select"}, 32'(bus.select), 32'(port));
    endtask

    task automatic set_all_weights(input int w);
        for (int i = 0; i < NP; i++) bus.weight[i*WW +: WW] = WW'(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.mode    = 1'b0;
        bus.request = 9'h1FF;
        set_all_weights(2);

        // Long reset with every port requesting
        for (int i = 0; i < 10; i++) step();
        expect_state("reset", -1, 1'b0);
        check_eq("reset.select", 32'(bus.select), 32'd0);

        // Round-robin, weight 2 each: 0,0,1,1,...,8,8,0
        rst = 1'b0;
        for (int k = 0; k < 19; k++) begin
            step();
            expect_state($sformatf("rr%0d", k), (k / 2) % NP, (k % 2) == 0);
        end

        // port0 weight 3, port8 weight 1: 0,0,0,8 repeating
        do_reset();
        bus.weight[0*WW +: WW] = 4'd3;
        bus.weight[8*WW +: WW] = 4'd1;
        bus.request = 9'b100000001;
        for (int k = 0; k < 12; k++) begin
            step();
            expect_state($sformatf("wt%0d", k), ((k % 4) == 3) ? 8 : 0, (k % 4) == 0 || (k % 4) == 3);
        end

        // Unlimited weight on port1; a mid-grant weight edit must not cut it
        do_reset();
        set_all_weights(2);
        bus.weight[1*WW +: WW] = 4'd0;
        bus.request = 9'b000000010;
        step();
        expect_state("unl0", 1, 1'b1);
        for (int k = 1; k < 20; k++) begin
            if (k == 8) bus.weight[1*WW +: WW] = 4'd1;
            step();
            expect_state($sformatf("unl%0d", k), 1, 1'b0);
        end
        bus.request = 9'b010000000;
        step();
        expect_state("unl_move", 7, 1'b1);

        // Sole requester port5, weight 2: continuous grant, one handover
        do_reset();
        set_all_weights(2);
        bus.request = 9'b000100000;
        step();
        expect_state("sole0", 5, 1'b1);
        for (int k = 1; k < 10; k++) begin
            step();
            expect_state($sformatf("sole%0d", k), 5, 1'b0);
        end
        bus.request = '0;
        step();
        expect_state("sole_idle", -1, 1'b0);
        check_eq("sole_idle.select", 32'(bus.select), 32'd5);

        // Fixed priority, weight 1 everywhere
        do_reset();
        bus.mode = 1'b1;
        set_all_weights(1);
        bus.request = 9'h1FF;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_state($sformatf("prio%0d", k), 0, k == 0);
        end
        bus.request = 9'h1FE;
        step();
        expect_state("prio_drop", 1, 1'b1);
        bus.request = 9'h1FF;
        step();
        expect_state("prio_back", 0, 1'b1);

        // Reset in the middle of port3's grant
        do_reset();
        bus.mode = 1'b0;
        set_all_weights(4);
        bus.request = 9'b000001000;
        step();
        expect_state("mid0", 3, 1'b1);
        step();
        expect_state("mid1", 3, 1'b0);
        rst = 1'b1;
        bus.request = 9'h1FF;
        step();
        expect_state("mid_rst", -1, 1'b0);
        check_eq("mid_rst.select", 32'(bus.select), 32'd0);
        rst = 1'b0;
        set_all_weights(2);
        step();
        expect_state("mid_restart", 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
